stat_update_scheduler: RTL and testbench

//  Sole writer of the four Tamagotchi stats (comida, energia, animo, salud). Latches one-cycle

---
 rtl/stat_update_scheduler_pkg.sv | 37 +++
 rtl/stat_update_scheduler_if.sv | 30 +++
 rtl/decay_tick_gen.sv | 46 ++++
 rtl/stat_update_scheduler.sv | 136 +++++++++++++
 tb/tb_stat_update_scheduler.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/stat_update_scheduler_pkg.sv
// Shared definitions for the stat update scheduler.
//   - mood codes driven on the state output
//   - event source indices (the index order is also the grant priority, 0 = highest)
//   - FSM encoding
//   - saturating +1 / -1 helpers on an 8-bit carrier (callers cast to their own width)
package stat_update_scheduler_pkg;

    localparam logic [3:0] ST_NORMAL  = 4'd0;
    localparam logic [3:0] ST_HAMBRE  = 4'd1;
    localparam logic [3:0] ST_CANSADO = 4'd2;
    localparam logic [3:0] ST_TRISTE  = 4'd3;
    localparam logic [3:0] ST_ENFERMO = 4'd4;
    localparam logic [3:0] ST_DORMIDO = 4'd5;
    localparam logic [3:0] ST_MUERTO  = 4'd6;

    typedef logic [2:0] src_t;

    localparam int   NUM_SRC   = 5;
    localparam src_t SRC_TICK  = 3'd0;
    localparam src_t SRC_CURAR = 3'd1;
    localparam src_t SRC_COMER = 3'd2;
    localparam src_t SRC_PROX  = 3'd3;
    localparam src_t SRC_TEMP  = 3'd4;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_APPLY = 2'd1;
    localparam logic [1:0] FSM_DEAD  = 2'd2;

    function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? max : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] v);
        return (v == 8'd0) ? 8'd0 : v - 8'd1;
    endfunction

endpackage

// File: rtl/stat_update_scheduler_if.sv
// Event / stat bundle between input conditioning, the scheduler and the display mux.
//   test, ev_comer, ev_curar, ev_prox, ev_temp, sns_luz : toward the scheduler
//   comida, energia, animo, salud (STAT_W), state (4), busy : from the scheduler
// master = event producer / stat reader, slave = the scheduler.
interface stat_update_scheduler_if #(
    parameter int STAT_W = 3
);
    logic              test;
    logic              ev_comer;
    logic              ev_curar;
    logic              ev_prox;
    logic              ev_temp;
    logic              sns_luz;
    logic [STAT_W-1:0] comida;
    logic [STAT_W-1:0] energia;
    logic [STAT_W-1:0] animo;
    logic [STAT_W-1:0] salud;
    logic [3:0]        state;
    logic              busy;

    modport master (
        output test, ev_comer, ev_curar, ev_prox, ev_temp, sns_luz,
        input  comida, energia, animo, salud, state, busy
    );

    modport slave (
        input  test, ev_comer, ev_curar, ev_prox, ev_temp, sns_luz,
        output comida, energia, animo, salud, state, busy
    );
endinterface

// File: rtl/decay_tick_gen.sv
// Decay tick generator: counts 0..period-1 and pulses tick for one clock on wrap.
//   clk, rst (sync, active high), test (level, selects TICK_TEST period), tick (out)
// Any change of test restarts the count at 0 so a period never mixes both settings.
module decay_tick_gen #(
    parameter int TICK_CYCLES = 500000000,
    parameter int TICK_TEST   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic test,
    output logic tick
);
    localparam int MAX_P = (TICK_CYCLES > TICK_TEST) ? TICK_CYCLES : TICK_TEST;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_T = CNT_W'(TICK_TEST - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             test_q, test_d;
    logic [CNT_W-1:0] last;

    always_comb begin
        last   = test_q ? LAST_T : LAST_N;
        tick   = 1'b0;
        test_d = test;
        if (test != test_q) begin
            cnt_d = '0;
        end else if (cnt_q == last) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // test_q follows test during reset so leaving reset is not seen as a mode change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            test_q <= test;
        end else begin
            cnt_q  <= cnt_d;
            test_q <= test_d;
        end
    end
endmodule

// File: rtl/stat_update_scheduler.sv
// Stat update scheduler: sole writer of comida/energia/animo/salud.
//   clk, rst (sync, active high)
//   bus (slave): event pulses, sns_luz, test in; stats, mood state, busy out
// Sticky pending flags latch every event; one is granted per two-clock slot.
//
// FSM states
//   IDLE  | grant highest-priority pending source, if any
//   APPLY | write saturated stats for the granted source (busy=1)
//   DEAD  | salud reached 0; stats frozen, events dropped until rst
module stat_update_scheduler
    import stat_update_scheduler_pkg::*;
#(
    parameter int STAT_W      = 3,
    parameter int STAT_MAX    = 5,
    parameter int TICK_CYCLES = 500000000,
    parameter int TICK_TEST   = 5000000
) (
    input logic                    clk,
    input logic                    rst,
    stat_update_scheduler_if.slave bus
);
    localparam logic [STAT_W-1:0] SMAX = STAT_W'(STAT_MAX);
    localparam logic [STAT_W-1:0] ONE  = STAT_W'(1);

    function automatic logic [STAT_W-1:0] inc(input logic [STAT_W-1:0] v);
        return STAT_W'(sat_add(8'(v), 8'(STAT_MAX)));
    endfunction

    function automatic logic [STAT_W-1:0] dec(input logic [STAT_W-1:0] v);
        return STAT_W'(sat_sub(8'(v)));
    endfunction

    logic                 tick;
    logic [NUM_SRC-1:0]   ev, grant;
    logic [NUM_SRC-1:0]   pend_q, pend_d;
    logic [1:0]           fsm_q, fsm_d;
    src_t                 src_q, src_d;
    logic [STAT_W-1:0]    com_q, com_d, ene_q, ene_d, ani_q, ani_d, sal_q, sal_d;
    logic [3:0]           state_q, state_d;

    decay_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES),
        .TICK_TEST   (TICK_TEST)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .test (bus.test),
        .tick (tick)
    );

    // Bit position equals source index, so the lowest set bit is the winner.
    assign ev    = {bus.ev_temp, bus.ev_prox, bus.ev_comer, bus.ev_curar, tick};
    assign grant = pend_q & (~pend_q + NUM_SRC'(1));

    always_comb begin
        fsm_d  = fsm_q;
        src_d  = src_q;
        pend_d = pend_q | ev;
        com_d  = com_q;
        ene_d  = ene_q;
        ani_d  = ani_q;
        sal_d  = sal_q;
        case (fsm_q)
            FSM_IDLE: begin
                if (|pend_q) begin
                    fsm_d = FSM_APPLY;
                    for (int i = NUM_SRC - 1; i >= 0; i--) begin
                        if (grant[i]) src_d = src_t'(i);
                    end
                    // New pulses are OR'd after the clear so a same-cycle re-pulse survives.
                    pend_d = (pend_q & ~grant) | ev;
                end
            end
            FSM_APPLY: begin
                case (src_q)
                    SRC_TICK: begin
                        com_d = dec(com_q);
                        ani_d = dec(ani_q);
                        ene_d = bus.sns_luz ? dec(ene_q) : inc(ene_q);
                        sal_d = (com_q == '0) ? dec(sal_q) : sal_q;
                    end
                    SRC_CURAR: sal_d = inc(sal_q);
                    SRC_COMER: com_d = inc(com_q);
                    SRC_PROX: begin
                        ani_d = inc(ani_q);
                        ene_d = dec(ene_q);
                    end
                    SRC_TEMP:  sal_d = dec(sal_q);
                    default:   ;
                endcase
                fsm_d = (sal_d == '0) ? FSM_DEAD : FSM_IDLE;
            end
            FSM_DEAD:  pend_d = '0;
            default:   fsm_d  = FSM_IDLE;
        endcase
    end

    always_comb begin
        if (fsm_q == FSM_DEAD)    state_d = ST_MUERTO;
        else if (!bus.sns_luz)    state_d = ST_DORMIDO;
        else if (sal_q <= ONE)    state_d = ST_ENFERMO;
        else if (com_q <= ONE)    state_d = ST_HAMBRE;
        else if (ene_q <= ONE)    state_d = ST_CANSADO;
        else if (ani_q <= ONE)    state_d = ST_TRISTE;
        else                      state_d = ST_NORMAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= FSM_IDLE;
            src_q   <= SRC_TICK;
            pend_q  <= '0;
            com_q   <= SMAX;
            ene_q   <= SMAX;
            ani_q   <= SMAX;
            sal_q   <= SMAX;
            state_q <= ST_NORMAL;
        end else begin
            fsm_q   <= fsm_d;
            src_q   <= src_d;
            pend_q  <= pend_d;
            com_q   <= com_d;
            ene_q   <= ene_d;
            ani_q   <= ani_d;
            sal_q   <= sal_d;
            state_q <= state_d;
        end
    end

    assign bus.comida  = com_q;
    assign bus.energia = ene_q;
    assign bus.animo   = ani_q;
    assign bus.salud   = sal_q;
    assign bus.state   = state_q;
    assign bus.busy    = (fsm_q == FSM_APPLY);
endmodule

// File: tb/tb_stat_update_scheduler.sv
module tb_stat_update_scheduler;
    localparam int SW = 3;
    localparam int SM = 5;
    localparam int TC = 16;
    localparam int TT = 4;

    localparam logic [3:0] E_NONE  = 4'b0000;
    localparam logic [3:0] E_COMER = 4'b0001;
    localparam logic [3:0] E_CURAR = 4'b0010;
    localparam logic [3:0] E_PROX  = 4'b0100;
    localparam logic [3:0] E_TEMP  = 4'b1000;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    stat_update_scheduler_if #(.STAT_W(SW)) bus ();

    stat_update_scheduler #(
        .STAT_W(SW), .STAT_MAX(SM), .TICK_CYCLES(TC), .TICK_TEST(TT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    // Pending events are a set of booleans; stats are plain integers clamped to [0,SM].
    int m_com, m_ene, m_ani, m_sal, m_st, m_cnt, m_src;
    int m_phase;            // 0 waiting, 1 applying, 2 dead
    bit m_tprev;
    bit m_pend[5];          // 0 tick, 1 curar, 2 comer, 3 prox, 4 temp (priority order)

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > SM) ? SM : v);
    endfunction

    always @(posedge clk) begin : model
        bit ev[5];
        bit tk;
        bit found;
        bit starve;
        int per;
        int nst;
        if (rst) begin
            m_com = SM; m_ene = SM; m_ani = SM; m_sal = SM;
            m_st = 0; m_phase = 0; m_cnt = 0; m_src = 0;
            m_tprev = bus.test;
            for (int i = 0; i < 5; i++) m_pend[i] = 0;
        end else begin
            per = m_tprev ? TT : TC;
            tk  = 0;
            if (bus.test != m_tprev) m_cnt = 0;
            else if (m_cnt == per - 1) begin tk = 1; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
            m_tprev = bus.test;

            if (m_phase == 2)        nst = 6;
            else if (!bus.sns_luz)   nst = 5;
            else if (m_sal <= 1)     nst = 4;
            else if (m_com <= 1)     nst = 1;
            else if (m_ene <= 1)     nst = 2;
            else if (m_ani <= 1)     nst = 3;
            else                     nst = 0;

            ev[0] = tk; ev[1] = bus.ev_curar; ev[2] = bus.ev_comer;
            ev[3] = bus.ev_prox; ev[4] = bus.ev_temp;

            if (m_phase == 0) begin
                found = 0;
                for (int i = 0; i < 5; i++)
                    if (!found && m_pend[i]) begin found = 1; m_src = i; m_pend[i] = 0; end
                if (found) m_phase = 1;
                for (int i = 0; i < 5; i++) m_pend[i] = m_pend[i] | ev[i];
            end else if (m_phase == 1) begin
                case (m_src)
                    0: begin
                        starve = (m_com == 0);
                        m_com = clamp(m_com - 1);
                        m_ani = clamp(m_ani - 1);
                        m_ene = clamp(m_ene + (bus.sns_luz ? -1 : 1));
                        if (starve) m_sal = clamp(m_sal - 1);
                    end
                    1: m_sal = clamp(m_sal + 1);
                    2: m_com = clamp(m_com + 1);
                    3: begin m_ani = clamp(m_ani + 1); m_ene = clamp(m_ene - 1); end
                    default: m_sal = clamp(m_sal - 1);
                endcase
                m_phase = (m_sal == 0) ? 2 : 0;
                for (int i = 0; i < 5; i++) m_pend[i] = m_pend[i] | ev[i];
            end else begin
                for (int i = 0; i < 5; i++) m_pend[i] = 0;
            end
            m_st = nst;
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        string      name;
        bit         rst;
        logic [3:0] ev;
        bit         luz;
        bit         test;
        int         wt;
        bit         chk;
        int         com, ene, ani, sal, st, busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input string n, input bit r, input logic [3:0] e, input bit l,
                                input bit t, input int w, input bit c, input int co, input int en,
                                input int an, input int sa, input int s, input int b);
        vec_t v;
        v.name = n; v.rst = r; v.ev = e; v.luz = l; v.test = t; v.wt = w; v.chk = c;
        v.com = co; v.ene = en; v.ani = an; v.sal = sa; v.st = s; v.busy = b;
        return v;
    endfunction

    task automatic drive_ev(input logic [3:0] e);
        bus.ev_comer = e[0];
        bus.ev_curar = e[1];
        bus.ev_prox  = e[2];
        bus.ev_temp  = e[3];
    endtask

    initial begin
        clk = 0; rst = 1; n_chk = 0; n_pass = 0;
        bus.sns_luz = 1; bus.test = 0;
        drive_ev(E_NONE);

        vt.push_back(mk("reset",          1, E_NONE,        1, 0, 0,  1, 5, 5, 5, 5, 0, 0));
        vt.push_back(mk("comer_sat",      0, E_COMER,       1, 0, 2,  1, 5, 5, 5, 5, 0, 0));
        vt.push_back(mk("reset_b",        1, E_NONE,        1, 0, 0,  1, 5, 5, 5, 5, 0, 0));
        vt.push_back(mk("temp1",          0, E_TEMP,        1, 0, 1,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk("temp_in_apply",  0, E_TEMP,        1, 0, 2,  1, 5, 5, 5, 3, 0, 0));
        vt.push_back(mk("curar_first",    0, E_CURAR|E_PROX,1, 0, 2,  1, 5, 5, 5, 4, 0, 0));
        vt.push_back(mk("prox_busy",      0, E_NONE,        1, 0, 0,  1, 5, 5, 5, 4, 0, 1));
        vt.push_back(mk("prox_applied",   0, E_NONE,        1, 0, 0,  1, 5, 4, 5, 4, 0, 0));
        vt.push_back(mk("reset_test",     1, E_NONE,        1, 1, 0,  1, 5, 5, 5, 5, 0, 0));
        vt.push_back(mk("four_ticks",     0, E_NONE,        1, 1, 18, 1, 1, 1, 1, 5, 1, 0));
        vt.push_back(mk("sleep_ticks",    0, E_NONE,        0, 1, 7,  1, 0, 3, 0, 4, 5, 0));
        vt.push_back(mk("starve_dead",    0, E_NONE,        0, 1, 15, 1, 0, 5, 0, 0, 6, 0));
        vt.push_back(mk("dead_ignores",   0, E_CURAR,       1, 1, 4,  1, 0, 5, 0, 0, 6, 0));
        vt.push_back(mk("reset_revive",   1, E_NONE,        1, 0, 0,  1, 5, 5, 5, 5, 0, 0));
        vt.push_back(mk("temp_a",         0, E_TEMP,        1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk("temp_regrant",   0, E_TEMP,        1, 0, 3,  1, 5, 5, 5, 3, 0, 0));
        vt.push_back(mk("temp_busy",      0, E_TEMP,        1, 0, 1,  1, 5, 5, 5, 3, 0, 1));
        vt.push_back(mk("rst_in_apply",   1, E_NONE,        1, 0, 0,  1, 5, 5, 5, 5, 0, 0));
        vt.push_back(mk("no_late_write",  0, E_NONE,        1, 0, 3,  1, 5, 5, 5, 5, 0, 0));

        repeat (2) @(negedge clk);
        foreach (vt[k]) begin
            rst = vt[k].rst;
            bus.sns_luz = vt[k].luz;
            bus.test = vt[k].test;
            drive_ev(vt[k].ev);
            @(negedge clk);
            rst = 0;
            drive_ev(E_NONE);
            repeat (vt[k].wt) @(negedge clk);
            if (vt[k].chk) begin
                check({vt[k].name, "_stats"},
                      int'({bus.comida, bus.energia, bus.animo, bus.salud}),
                      int'({SW'(vt[k].com), SW'(vt[k].ene), SW'(vt[k].ani), SW'(vt[k].sal)}));
                check({vt[k].name, "_state_busy"}, int'({bus.state, bus.busy}),
                      int'({4'(vt[k].st), 1'(vt[k].busy)}));
            end
        end

        // ---------------- randomized run against the model ----------------
        rst = 1;
        bus.test = 0;
        bus.sns_luz = 1;
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 4000; c++) begin
            check($sformatf("rand_cyc%0d", c),
                  int'({bus.comida, bus.energia, bus.animo, bus.salud, bus.state, bus.busy}),
                  int'({SW'(m_com), SW'(m_ene), SW'(m_ani), SW'(m_sal), 4'(m_st), (m_phase == 1)}));
            rst = ($urandom_range(0, 399) == 0);
            drive_ev({($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0)});
            if ($urandom_range(0, 49) == 0) bus.sns_luz = ~bus.sns_luz;
            if ($urandom_range(0, 149) == 0) bus.test = ~bus.test;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
